decode_stage: RTL and testbench
===============================

DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 Parameter XLEN, default 64, SHALL set the immediate width; legal values are 32 and 64.
REQ-003 Parameter PCW, default 64, SHALL set the PC side-band width.
REQ-004 clk  in  1  sole clock; all state updates on its rising edge.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 flush  in  1  drops all held and incoming instructions this cycle.
REQ-007 in_valid  in  1  fetch presents an instruction.
REQ-008 in_ready  out  1  stage can accept; transfer when in_valid & in_ready.
REQ-009 in_instr  in  32  raw instruction word.
REQ-010 in_pc  in  PCW  PC of in_instr.
REQ-011 out_valid  out  1  decoded bundle valid.
REQ-012 out_ready  in  1  consumer accepts; transfer when out_valid & out_ready.
REQ-013 out_pc, out_opcode[7], out_rd[5], out_rs1[5], out_rs2[5], out_funct3[3], out_funct7[7], out_imm[XLEN], out_format[3]  out  decoded fields, registered.
REQ-014 out_rd_we, out_rs1_used, out_rs2_used, out_illegal  out  1 each  register-use and exception flags.

Function
REQ-015 Formats SHALL be encoded as R=0, I=1, S=2, B=3, U=4, J=5, invalid=7.
REQ-016 Opcode-to-format mapping SHALL be:
- 0110011 -> R
- 0010011, 0000011, 1100111 -> I
- 0100011 -> S
- 1100011 -> B
- 0110111, 0010111 -> U
- 1101111 -> J
- 0011011 (I) and 0111011 (R) only when XLEN=64.
REQ-017 Immediates SHALL be sign-extended from instr[31] to XLEN:
- I: instr[31:20]
- S: {instr[31:25], instr[11:7]}
- B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}
- U: {instr[31:12], 12'b0}
- J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}
- R: 0.
REQ-018 Fields not used by the format SHALL be driven 0.
REQ-019 funct7 SHALL be populated only for R-type and opcode 0011011.
REQ-020 out_rs1_used SHALL be 1 for R/I/S/B; out_rs2_used SHALL be 1 for R/S/B.
REQ-021 out_rd_we SHALL be 1 for R/I/U/J with rd!=0, and 0 otherwise.
REQ-022 out_illegal SHALL be 1, with format=7 and all fields/flags 0 except out_pc and out_opcode, on any of:
- instr[1:0]!=2'b11
- unmapped opcode
- JALR with funct3!=000
- XLEN=32 with OP-IMM funct3 001/101 and instr[25]=1.
REQ-023 Latency SHALL be exactly 1 cycle: a bundle accepted at edge N is on out_* with out_valid=1 after edge N.
REQ-024 The stage SHALL contain one output register plus one skid entry, giving full throughput (one transfer per cycle) under continuous out_ready=1.
REQ-025 in_ready SHALL be a registered signal equal to !skid_valid.
REQ-026 If an input is accepted while out_valid=1 and out_ready=0, the decoded bundle SHALL be stored in the skid entry.
REQ-027 When the output transfers, the skid entry, if valid, SHALL move to the output register next edge, ahead of any new input.
REQ-028 Bundles SHALL leave in acceptance order, with no loss or duplication.
REQ-029 out_* SHALL remain stable while out_valid=1 and out_ready=0.
REQ-030 flush=1 SHALL clear out_valid and skid_valid at that edge, discard any same-cycle input, and leave in_ready=1 on the next cycle; flush overrides all simultaneous events.
REQ-031 Illegal instructions SHALL flow through the pipeline like legal ones; the stage SHALL NOT stall on them.

Reset
REQ-032 On rst=1 at a rising edge:
- out_valid=0, skid_valid=0, in_ready=1
- all out_* data=0, except out_format=7.
REQ-033 Reset mid-stream SHALL discard held bundles; rst takes priority over flush and handshakes.
REQ-034 in_ready SHALL read 1 in the first cycle after reset deasserts.

Verification
REQ-035 XLEN=64; in_instr=0xFFF08293 accepted, out_ready=1 -> next cycle:
- out_valid=1, rd=5, rs1=1, format=1
- imm=0xFFFF_FFFF_FFFF_FFFF
- rd_we=1, rs1_used=1, rs2_used=0, illegal=0.
REQ-036 in_instr=0x008000EF -> format=5, rd=1, imm=8, rd_we=1, rs1_used=0.
REQ-037 Backpressure: out_ready=0, feed A,B,C back-to-back ->
- A and B accepted, in_ready=0 the cycle after B
- C held by fetch
- with out_ready=1, outputs A,B,C on consecutive cycles.
REQ-038 XLEN=32; in_instr=0x0000809B -> illegal=1, format=7, rd_we=0, imm=0, out_pc carried.
REQ-039 Output and skid both full, then flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1, no flushed instruction ever emitted.
REQ-040 rst=1 for one cycle with both entries full -> out_valid=0, in_ready=1, out_format=7 next cycle.

Source files
------------

// File: rtl/decode_stage.sv
// RV32/RV64 base-ISA decode stage with one-cycle latency and a single skid entry.
// The output register and skid entry allow one transfer per cycle under continuous
// downstream ready. in_ready is a registered signal.
module decode_stage #(
    parameter int XLEN = 64,
    parameter int PCW  = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [PCW-1:0]  in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [PCW-1:0]  out_pc,
    output logic [6:0]      out_opcode,
    output logic [4:0]      out_rd,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [2:0]      out_funct3,
    output logic [6:0]      out_funct7,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_format,
    output logic            out_rd_we,
    output logic            out_rs1_used,
    output logic            out_rs2_used,
    output logic            out_illegal
);

    localparam logic [2:0] FMT_R   = 3'd0;
    localparam logic [2:0] FMT_I   = 3'd1;
    localparam logic [2:0] FMT_S   = 3'd2;
    localparam logic [2:0] FMT_B   = 3'd3;
    localparam logic [2:0] FMT_U   = 3'd4;
    localparam logic [2:0] FMT_J   = 3'd5;
    localparam logic [2:0] FMT_INV = 3'd7;

    typedef struct packed {
        logic [PCW-1:0]  pc;
        logic [6:0]      opcode;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [2:0]      funct3;
        logic [6:0]      funct7;
        logic [XLEN-1:0] imm;
        logic [2:0]      fmt;
        logic            rd_we;
        logic            rs1_used;
        logic            rs2_used;
        logic            illegal;
    } bundle_t;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [2:0]  fmt_raw;
    logic        illegal;
    logic [31:0] imm32;
    bundle_t     dec;

    bundle_t out_q, out_d;
    bundle_t skid_q, skid_d;
    logic    out_valid_q, out_valid_d;
    logic    skid_valid_q, skid_valid_d;
    logic    in_ready_q, in_ready_d;
    logic    accept;
    logic    out_free;

    assign opcode = in_instr[6:0];
    assign funct3 = in_instr[14:12];

    // Map the major opcode to an instruction format; RV64-only W opcodes are gated by XLEN.
    always_comb begin
        fmt_raw = FMT_INV;
        case (opcode)
            7'b0110011:                         fmt_raw = FMT_R;
            7'b0010011, 7'b0000011, 7'b1100111: fmt_raw = FMT_I;
            7'b0100011:                         fmt_raw = FMT_S;
            7'b1100011:                         fmt_raw = FMT_B;
            7'b0110111, 7'b0010111:             fmt_raw = FMT_U;
            7'b1101111:                         fmt_raw = FMT_J;
            7'b0011011:                         fmt_raw = (XLEN == 64) ? FMT_I : FMT_INV;
            7'b0111011:                         fmt_raw = (XLEN == 64) ? FMT_R : FMT_INV;
            default:                            fmt_raw = FMT_INV;
        endcase
    end

    // Exception detection; a 6-bit shift amount is illegal on a 32-bit datapath.
    assign illegal = (in_instr[1:0] != 2'b11)
                   | (fmt_raw == FMT_INV)
                   | ((opcode == 7'b1100111) && (funct3 != 3'b000))
                   | ((XLEN == 32) && (opcode == 7'b0010011)
                      && ((funct3 == 3'b001) || (funct3 == 3'b101)) && in_instr[25]);

    // Build the decoded bundle; unused fields stay zero, illegal words keep only pc/opcode.
    always_comb begin
        dec        = '0;
        imm32      = '0;
        dec.pc     = in_pc;
        dec.opcode = opcode;
        dec.fmt    = FMT_INV;
        if (illegal) begin
            dec.illegal = 1'b1;
        end else begin
            dec.fmt = fmt_raw;
            case (fmt_raw)
                FMT_R: begin
                    dec.rd       = in_instr[11:7];
                    dec.rs1      = in_instr[19:15];
                    dec.rs2      = in_instr[24:20];
                    dec.funct3   = funct3;
                    dec.funct7   = in_instr[31:25];
                    dec.rs1_used = 1'b1;
                    dec.rs2_used = 1'b1;
                end
                FMT_I: begin
                    dec.rd       = in_instr[11:7];
                    dec.rs1      = in_instr[19:15];
                    dec.funct3   = funct3;
                    dec.funct7   = (opcode == 7'b0011011) ? in_instr[31:25] : 7'd0;
                    dec.rs1_used = 1'b1;
                    imm32        = {{20{in_instr[31]}}, in_instr[31:20]};
                end
                FMT_S: begin
                    dec.rs1      = in_instr[19:15];
                    dec.rs2      = in_instr[24:20];
                    dec.funct3   = funct3;
                    dec.rs1_used = 1'b1;
                    dec.rs2_used = 1'b1;
                    imm32        = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
                end
                FMT_B: begin
                    dec.rs1      = in_instr[19:15];
                    dec.rs2      = in_instr[24:20];
                    dec.funct3   = funct3;
                    dec.rs1_used = 1'b1;
                    dec.rs2_used = 1'b1;
                    imm32        = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                                    in_instr[30:25], in_instr[11:8], 1'b0};
                end
                FMT_U: begin
                    dec.rd = in_instr[11:7];
                    imm32  = {in_instr[31:12], 12'b0};
                end
                FMT_J: begin
                    dec.rd = in_instr[11:7];
                    imm32  = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                              in_instr[20], in_instr[30:21], 1'b0};
                end
                default: ;
            endcase
            dec.imm   = XLEN'($signed(imm32));
            dec.rd_we = ((fmt_raw == FMT_R) || (fmt_raw == FMT_I) ||
                         (fmt_raw == FMT_U) || (fmt_raw == FMT_J)) && (dec.rd != 5'd0);
        end
    end

    assign accept   = in_valid & in_ready_q;
    assign out_free = ~out_valid_q | out_ready;

    // Next-state for output register and skid entry; skid drains ahead of new input.
    always_comb begin
        out_d        = out_q;
        skid_d       = skid_q;
        out_valid_d  = out_valid_q;
        skid_valid_d = skid_valid_q;
        if (flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (out_free) begin
            if (skid_valid_q) begin
                out_d        = skid_q;
                out_valid_d  = 1'b1;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                out_d       = dec;
                out_valid_d = 1'b1;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (accept) begin
            skid_d       = dec;
            skid_valid_d = 1'b1;
        end
        in_ready_d = ~skid_valid_d;
    end

    // Pipeline state registers with synchronous reset to an empty, ready stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b1;
            out_q        <= '0;
            out_q.fmt    <= FMT_INV;
            skid_q       <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            skid_valid_q <= skid_valid_d;
            in_ready_q   <= in_ready_d;
            out_q        <= out_d;
            skid_q       <= skid_d;
        end
    end

    assign in_ready     = in_ready_q;
    assign out_valid    = out_valid_q;
    assign out_pc       = out_q.pc;
    assign out_opcode   = out_q.opcode;
    assign out_rd       = out_q.rd;
    assign out_rs1      = out_q.rs1;
    assign out_rs2      = out_q.rs2;
    assign out_funct3   = out_q.funct3;
    assign out_funct7   = out_q.funct7;
    assign out_imm      = out_q.imm;
    assign out_format   = out_q.fmt;
    assign out_rd_we    = out_q.rd_we;
    assign out_rs1_used = out_q.rs1_used;
    assign out_rs2_used = out_q.rs2_used;
    assign out_illegal  = out_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: scoreboard of hand-computed expected bundles,
// pushed at input acceptance and popped at output transfer, plus an XLEN=32 instance.
module tb_decode_stage;

    typedef struct packed {
        logic [63:0] pc;
        logic [6:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [63:0] imm;
        logic [2:0]  fmt;
        logic        we;
        logic        u1;
        logic        u2;
        logic        ill;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_instr;
    logic [63:0] in_pc;
    logic        out_ready;

    logic        in_ready;
    logic        out_valid;
    logic [63:0] out_pc;
    logic [6:0]  out_opcode;
    logic [4:0]  out_rd, out_rs1, out_rs2;
    logic [2:0]  out_funct3;
    logic [6:0]  out_funct7;
    logic [63:0] out_imm;
    logic [2:0]  out_format;
    logic        out_rd_we, out_rs1_used, out_rs2_used, out_illegal;

    logic        in_ready32;
    logic        out_valid32;
    logic [63:0] out_pc32;
    logic [6:0]  out_opcode32;
    logic [4:0]  out_rd32, out_rs1_32, out_rs2_32;
    logic [2:0]  out_funct3_32;
    logic [6:0]  out_funct7_32;
    logic [31:0] out_imm32;
    logic [2:0]  out_format32;
    logic        out_rd_we32, out_rs1_used32, out_rs2_used32, out_illegal32;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    exp_t cur_exp;
    logic [31:0] instr_tab [16];
    exp_t        exp_tab   [16];

    decode_stage #(.XLEN(64), .PCW(64)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_opcode(out_opcode), .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
        .out_funct3(out_funct3), .out_funct7(out_funct7), .out_imm(out_imm),
        .out_format(out_format), .out_rd_we(out_rd_we), .out_rs1_used(out_rs1_used),
        .out_rs2_used(out_rs2_used), .out_illegal(out_illegal)
    );

    decode_stage #(.XLEN(32), .PCW(64)) dut32 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready32), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid32), .out_ready(out_ready), .out_pc(out_pc32),
        .out_opcode(out_opcode32), .out_rd(out_rd32), .out_rs1(out_rs1_32), .out_rs2(out_rs2_32),
        .out_funct3(out_funct3_32), .out_funct7(out_funct7_32), .out_imm(out_imm32),
        .out_format(out_format32), .out_rd_we(out_rd_we32), .out_rs1_used(out_rs1_used32),
        .out_rs2_used(out_rs2_used32), .out_illegal(out_illegal32)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t mk(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                                input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                                input logic [63:0] imm, input logic [2:0] fmt, input logic we,
                                input logic u1, input logic u2, input logic ill);
        exp_t e;
        e.pc = '0; e.op = op; e.rd = rd; e.rs1 = rs1; e.rs2 = rs2; e.f3 = f3; e.f7 = f7;
        e.imm = imm; e.fmt = fmt; e.we = we; e.u1 = u1; e.u2 = u2; e.ill = ill;
        return e;
    endfunction

    function automatic exp_t obs64();
        exp_t o;
        o.pc = out_pc; o.op = out_opcode; o.rd = out_rd; o.rs1 = out_rs1; o.rs2 = out_rs2;
        o.f3 = out_funct3; o.f7 = out_funct7; o.imm = out_imm; o.fmt = out_format;
        o.we = out_rd_we; o.u1 = out_rs1_used; o.u2 = out_rs2_used; o.ill = out_illegal;
        return o;
    endfunction

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int idx, input logic [63:0] pc);
        in_instr   = instr_tab[idx];
        in_pc      = pc;
        cur_exp    = exp_tab[idx];
        cur_exp.pc = pc;
    endtask

    // One clock: scoreboard activity at the falling edge, then return 1 time unit after rise.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        if (rst || flush) begin
            sb.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_output", 256'(out_valid), 256'(1'b0));
                end else begin
                    e = sb.pop_front();
                    chk("bundle", 256'(obs64()), 256'(e));
                    $display("OUT pc=%0h op=%0h fmt=%0d imm=%0h ill=%0b", out_pc, out_opcode,
                             out_format, out_imm, out_illegal);
                end
            end
            if (in_valid && in_ready) begin
                sb.push_back(cur_exp);
                $display("IN  pc=%0h instr=%08h", in_pc, in_instr);
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        instr_tab[0]  = 32'hFFF08293; exp_tab[0]  = mk(7'h13, 5'd5, 5'd1, 5'd0, 3'd0, 7'h00, 64'hFFFF_FFFF_FFFF_FFFF, 3'd1, 1'b1, 1'b1, 1'b0, 1'b0);
        instr_tab[1]  = 32'h008000EF; exp_tab[1]  = mk(7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 64'd8, 3'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        instr_tab[2]  = 32'h402081B3; exp_tab[2]  = mk(7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 64'd0, 3'd0, 1'b1, 1'b1, 1'b1, 1'b0);
        instr_tab[3]  = 32'hFE20AE23; exp_tab[3]  = mk(7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'h00, 64'hFFFF_FFFF_FFFF_FFFC, 3'd2, 1'b0, 1'b1, 1'b1, 1'b0);
        instr_tab[4]  = 32'h00208863; exp_tab[4]  = mk(7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'h00, 64'd16, 3'd3, 1'b0, 1'b1, 1'b1, 1'b0);
        instr_tab[5]  = 32'h12345537; exp_tab[5]  = mk(7'h37, 5'd10, 5'd0, 5'd0, 3'd0, 7'h00, 64'h0000_0000_1234_5000, 3'd4, 1'b1, 1'b0, 1'b0, 1'b0);
        instr_tab[6]  = 32'h80000537; exp_tab[6]  = mk(7'h37, 5'd10, 5'd0, 5'd0, 3'd0, 7'h00, 64'hFFFF_FFFF_8000_0000, 3'd4, 1'b1, 1'b0, 1'b0, 1'b0);
        instr_tab[7]  = 32'h00000013; exp_tab[7]  = mk(7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 64'd0, 3'd1, 1'b0, 1'b1, 1'b0, 1'b0);
        instr_tab[8]  = 32'hFFF08290; exp_tab[8]  = mk(7'h10, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 64'd0, 3'd7, 1'b0, 1'b0, 1'b0, 1'b1);
        instr_tab[9]  = 32'h000090E7; exp_tab[9]  = mk(7'h67, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 64'd0, 3'd7, 1'b0, 1'b0, 1'b0, 1'b1);
        instr_tab[10] = 32'h0000809B; exp_tab[10] = mk(7'h1B, 5'd1, 5'd1, 5'd0, 3'd0, 7'h00, 64'd0, 3'd1, 1'b1, 1'b1, 1'b0, 1'b0);
        instr_tab[11] = 32'h02009093; exp_tab[11] = mk(7'h13, 5'd1, 5'd1, 5'd0, 3'd1, 7'h00, 64'h20, 3'd1, 1'b1, 1'b1, 1'b0, 1'b0);
        instr_tab[12] = 32'h0020823B; exp_tab[12] = mk(7'h3B, 5'd4, 5'd1, 5'd2, 3'd0, 7'h00, 64'd0, 3'd0, 1'b1, 1'b1, 1'b1, 1'b0);
        instr_tab[13] = 32'h0000007F; exp_tab[13] = mk(7'h7F, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 64'd0, 3'd7, 1'b0, 1'b0, 1'b0, 1'b1);
        instr_tab[14] = 32'h4000809B; exp_tab[14] = mk(7'h1B, 5'd1, 5'd1, 5'd0, 3'd0, 7'h20, 64'h400, 3'd1, 1'b1, 1'b1, 1'b0, 1'b0);
        instr_tab[15] = 32'h004100E7; exp_tab[15] = mk(7'h67, 5'd1, 5'd2, 5'd0, 3'd0, 7'h00, 64'd4, 3'd1, 1'b1, 1'b1, 1'b0, 1'b0);

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_instr = '0; in_pc = '0; cur_exp = '0;

        // Reset state
        tick(); tick();
        chk("rst_out_valid", 256'(out_valid), 256'(1'b0));
        chk("rst_in_ready", 256'(in_ready), 256'(1'b1));
        chk("rst_format", 256'(out_format), 256'(3'd7));
        chk("rst_imm", 256'(out_imm), 256'(64'd0));
        chk("rst_pc", 256'(out_pc), 256'(64'd0));
        rst = 1'b0;
        tick();
        chk("post_rst_in_ready", 256'(in_ready), 256'(1'b1));

        // Single-cycle latency for the addi example
        out_ready = 1'b1;
        drive(0, 64'h100); in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("lat_out_valid", 256'(out_valid), 256'(1'b1));
        chk("lat_imm", 256'(out_imm), 256'(64'hFFFF_FFFF_FFFF_FFFF));
        chk("x32_imm_sext", 256'(out_imm32), 256'(32'hFFFF_FFFF));
        tick();
        chk("idle_out_valid", 256'(out_valid), 256'(1'b0));

        // Back-to-back stream at full throughput
        for (int i = 0; i < 16; i++) begin
            drive(i, 64'h1000 + 64'(4 * i)); in_valid = 1'b1;
            tick();
            chk("stream_in_ready", 256'(in_ready), 256'(1'b1));
            if (i == 10) begin
                chk("x32_w_illegal", 256'(out_illegal32), 256'(1'b1));
                chk("x32_w_format", 256'(out_format32), 256'(3'd7));
                chk("x32_w_rd_we", 256'(out_rd_we32), 256'(1'b0));
                chk("x32_w_imm", 256'(out_imm32), 256'(32'd0));
                chk("x32_w_pc", 256'(out_pc32), 256'(64'h1028));
                chk("x32_w_opcode", 256'(out_opcode32), 256'(7'h1B));
            end
            if (i == 11) begin
                chk("x32_slli_illegal", 256'(out_illegal32), 256'(1'b1));
            end
            if (i == 12) begin
                chk("x32_addw_illegal", 256'(out_illegal32), 256'(1'b1));
            end
        end
        in_valid = 1'b0;
        tick(); tick();

        // Backpressure: A, B accepted, C held off, then drain in order
        out_ready = 1'b0;
        drive(2, 64'h2000); in_valid = 1'b1;
        tick();
        chk("bp_ready_after_a", 256'(in_ready), 256'(1'b1));
        drive(3, 64'h2004);
        tick();
        chk("bp_ready_after_b", 256'(in_ready), 256'(1'b0));
        drive(5, 64'h2008);
        tick();
        chk("bp_hold_pc", 256'(out_pc), 256'(64'h2000));
        chk("bp_hold_ready", 256'(in_ready), 256'(1'b0));
        tick();
        chk("bp_stable_pc", 256'(out_pc), 256'(64'h2000));
        out_ready = 1'b1;
        tick();
        chk("bp_b_valid", 256'(out_valid), 256'(1'b1));
        chk("bp_b_pc", 256'(out_pc), 256'(64'h2004));
        tick();
        in_valid = 1'b0;
        chk("bp_c_valid", 256'(out_valid), 256'(1'b1));
        chk("bp_c_pc", 256'(out_pc), 256'(64'h2008));
        tick();
        chk("bp_empty", 256'(out_valid), 256'(1'b0));

        // Flush with both entries full and an instruction on the input
        out_ready = 1'b0;
        drive(4, 64'h3000); in_valid = 1'b1; tick();
        drive(6, 64'h3004); tick();
        drive(1, 64'h3008); flush = 1'b1; tick();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_out_valid", 256'(out_valid), 256'(1'b0));
        chk("flush_in_ready", 256'(in_ready), 256'(1'b1));
        out_ready = 1'b1;
        tick(); tick(); tick();
        // Flush while ready: same-cycle input is dropped
        drive(7, 64'h3100); in_valid = 1'b1; flush = 1'b1; tick();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_drop_valid", 256'(out_valid), 256'(1'b0));
        tick(); tick();

        // Reset mid-stream with both entries full
        out_ready = 1'b0;
        drive(12, 64'h4000); in_valid = 1'b1; tick();
        drive(14, 64'h4004); tick();
        in_valid = 1'b0; rst = 1'b1; tick();
        rst = 1'b0;
        chk("mid_rst_out_valid", 256'(out_valid), 256'(1'b0));
        chk("mid_rst_in_ready", 256'(in_ready), 256'(1'b1));
        chk("mid_rst_format", 256'(out_format), 256'(3'd7));
        out_ready = 1'b1;
        tick(); tick();

        // Final drain with a bounded budget
        for (int k = 0; k < 20 && sb.size() > 0; k++) tick();
        chk("scoreboard_empty", 256'(sb.size()), 256'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
